// File: rtl/s2_window_sequencer.sv
// Stage-2 window sequencer: sweeps the combinational processing block across every
// filter and 3x3 window position, captures each ReLU result into a local buffer, then
// streams the buffer downstream over valid/ready in address order.
module s2_window_sequencer #(
    parameter int unsigned NFILT   = 4,
    parameter int unsigned OUT_DIM = 6,
    parameter int unsigned DWIDTH  = 35
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        proc_dir,
    output logic [2:0]        proc_row,
    output logic [2:0]        proc_col,
    input  logic [DWIDTH-1:0] res_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [7:0]        out_addr,
    output logic              out_last
);

    localparam int unsigned NOUT      = NFILT * OUT_DIM * OUT_DIM;
    localparam logic [2:0]  MAX_POS   = 3'(OUT_DIM - 1);
    localparam logic [1:0]  MAX_DIR   = 2'(NFILT - 1);
    localparam logic [7:0]  PLANE     = 8'(OUT_DIM * OUT_DIM);
    localparam logic [7:0]  ROW_SIZE  = 8'(OUT_DIM);
    localparam logic [7:0]  LAST_ADDR = 8'(NOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        dir_q;
    logic [2:0]        row_q;
    logic [2:0]        col_q;
    logic              out_valid_q;
    logic [7:0]        out_addr_q;
    logic [DWIDTH-1:0] out_data_q;
    logic              done_q;

    logic [DWIDTH-1:0] mem [NOUT];

    logic       wr_en;
    logic [7:0] wr_addr;
    logic       coord_last;
    logic       last_beat;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is dropped on purpose.
                if (start && !done_q) begin
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (coord_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_beat) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath-control decode
    always_comb begin
        busy       = (state_q != StIdle);
        wr_en      = (state_q == StCompute) && !rst;
        wr_addr    = {6'd0, dir_q} * PLANE + {5'd0, row_q} * ROW_SIZE + {5'd0, col_q};
        coord_last = (dir_q == MAX_DIR) && (row_q == MAX_POS) && (col_q == MAX_POS);
        last_beat  = (state_q == StDrain) && out_valid_q && out_ready
                     && (out_addr_q == LAST_ADDR);
        out_last   = out_valid_q && (out_addr_q == LAST_ADDR);
    end

    assign proc_dir  = dir_q;
    assign proc_row  = row_q;
    assign proc_col  = col_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

    // Window coordinate counter: col fastest, then row, then filter; wraps to 0/0/0
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (state_q == StCompute) begin
            if (col_q == MAX_POS) begin
                col_q <= '0;
                if (row_q == MAX_POS) begin
                    row_q <= '0;
                    dir_q <= (dir_q == MAX_DIR) ? 2'd0 : dir_q + 2'd1;
                end else begin
                    row_q <= row_q + 3'd1;
                end
            end else begin
                col_q <= col_q + 3'd1;
            end
        end
    end

    // Result buffer capture; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= res_in;
        end
    end

    // Output stream: first DRAIN cycle fetches entry 0, each handshake fetches the next
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == StDrain) begin
                if (!out_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= mem[out_addr_q];
                end else if (out_ready) begin
                    if (out_addr_q == LAST_ADDR) begin
                        out_valid_q <= 1'b0;
                        out_addr_q  <= '0;
                        out_data_q  <= '0;
                        done_q      <= 1'b1;
                    end else begin
                        out_addr_q <= out_addr_q + 8'd1;
                        out_data_q <= mem[out_addr_q + 8'd1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_s2_window_sequencer.sv
// Bench for s2_window_sequencer: a timeline vector table on a reference pass, then
// randomized data/ready passes scored against an address-ordered model of the buffer.
module tb_s2_window_sequencer;

    localparam int DW = 35;
    localparam int N  = 144;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [1:0]    proc_dir;
    logic [2:0]    proc_row;
    logic [2:0]    proc_col;
    logic [DW-1:0] res_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [7:0]    out_addr;
    logic          out_last;

    int n_pass;
    int n_total;

    // Expected buffer contents, indexed by f*36 + r*6 + c.
    logic [DW-1:0] model_val [N];
    logic [54:0]   rec [400];

    typedef struct {
        int          cyc;
        logic [54:0] exp;
    } vec_t;
    vec_t vecs [14];

    s2_window_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .proc_dir  (proc_dir),
        .proc_row  (proc_row),
        .proc_col  (proc_col),
        .res_in    (res_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processing block stand-in: returns the value stored for the requested window.
    int res_idx;
    assign res_idx = int'(proc_dir) * 36 + int'(proc_row) * 6 + int'(proc_col);
    assign res_in  = (res_idx < N) ? model_val[res_idx] : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_total++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [54:0] obs();
        return {busy, out_valid, out_last, done, proc_dir, proc_row, proc_col, out_addr, out_data};
    endfunction

    function automatic logic [54:0] mk(input logic b, input logic v, input logic l, input logic d,
                                       input int dir, input int row, input int col,
                                       input int addr, input int data);
        return {b, v, l, d, 2'(dir), 3'(row), 3'(col), 8'(addr), 35'(data)};
    endfunction

    function automatic logic ready_val(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic fill_model(input bit random_vals);
        logic [63:0] r;
        for (int k = 0; k < N; k++) begin
            if (random_vals) begin
                r = {32'($urandom), 32'($urandom)};
                model_val[k] = r[DW-1:0];
            end else begin
                model_val[k] = 35'((k / 36) * 1000 + ((k % 36) / 6) * 10 + (k % 6));
            end
        end
    endtask

    // Cycle 0 is the cycle start is high; with out_ready=1 beat k lands at cycle 146+k.
    task automatic init_vecs();
        vecs[0]  = '{cyc: 0,   exp: mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{cyc: 1,   exp: mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{cyc: 7,   exp: mk(1, 0, 0, 0, 0, 1, 0, 0, 0)};
        vecs[3]  = '{cyc: 37,  exp: mk(1, 0, 0, 0, 1, 0, 0, 0, 0)};
        vecs[4]  = '{cyc: 73,  exp: mk(1, 0, 0, 0, 2, 0, 0, 0, 0)};
        vecs[5]  = '{cyc: 109, exp: mk(1, 0, 0, 0, 3, 0, 0, 0, 0)};
        vecs[6]  = '{cyc: 144, exp: mk(1, 0, 0, 0, 3, 5, 5, 0, 0)};
        vecs[7]  = '{cyc: 145, exp: mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{cyc: 146, exp: mk(1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{cyc: 153, exp: mk(1, 1, 0, 0, 0, 0, 0, 7, 11)};
        vecs[10] = '{cyc: 189, exp: mk(1, 1, 0, 0, 0, 0, 0, 43, 1011)};
        vecs[11] = '{cyc: 289, exp: mk(1, 1, 1, 0, 0, 0, 0, 143, 3055)};
        vecs[12] = '{cyc: 290, exp: mk(0, 0, 0, 1, 0, 0, 0, 0, 0)};
        vecs[13] = '{cyc: 291, exp: mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    endtask

    // One pass from start; abort_cyc >= 0 asserts rst during that cycle.
    task automatic run_pass(input int ready_mode, input bit pokes, input int abort_cyc,
                            input bit record);
        int            cyc;
        int            exp_addr;
        int            n_done;
        int            done_cyc;
        int            n_seen;
        int            i;
        bit            finished;
        bit            prev_stall;
        logic [7:0]    prev_addr;
        logic [DW-1:0] prev_data;
        bit            seen [N];

        foreach (seen[k]) seen[k] = 1'b0;
        cyc = 0; exp_addr = 0; n_done = 0; done_cyc = -1;
        finished = 1'b0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;

        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = ready_val(ready_mode, 0);

        while (!finished) begin
            @(negedge clk);
            if (record && cyc < 400) rec[cyc] = obs();
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                check("abort_clears_outputs", 128'(obs()), '0);
                check("no_done_on_abort", n_done, 0);
                finished = 1'b1;
            end else begin
                if (cyc >= 1 && cyc <= N) begin
                    i = cyc - 1;
                    check($sformatf("coord_%0d", i), {busy, proc_dir, proc_row, proc_col},
                          {1'b1, 2'(i / 36), 3'((i / 6) % 6), 3'(i % 6)});
                    if (proc_row < 6 && proc_col < 6) seen[res_idx] = 1'b1;
                end
                if (prev_stall) begin
                    check("stall_hold", {out_valid, out_addr, out_data},
                          {1'b1, prev_addr, prev_data});
                end
                if (out_valid && out_ready) begin
                    if (exp_addr >= N) begin
                        fail_now("extra_beat", int'(out_addr), N);
                    end else begin
                        check($sformatf("beat_%0d", exp_addr), {out_addr, out_last, out_data},
                              {8'(exp_addr), exp_addr == N - 1, model_val[exp_addr]});
                    end
                    exp_addr++;
                end
                prev_stall = out_valid && !out_ready;
                prev_addr  = out_addr;
                prev_data  = out_data;
                if (done) begin
                    n_done++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (done_cyc >= 0 && cyc == done_cyc + 2) begin
                    n_seen = 0;
                    foreach (seen[k]) if (seen[k]) n_seen++;
                    check("idle_after_done", {busy, done, out_valid}, 3'b000);
                    check("beats_delivered", exp_addr, N);
                    check("single_done", n_done, 1);
                    check("distinct_tuples", n_seen, N);
                    finished = 1'b1;
                end
                if (!finished && cyc >= 1500) begin
                    fail_now("pass_timeout", cyc, 0);
                    finished = 1'b1;
                end
            end
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
                // Pokes land in COMPUTE, in DRAIN, and on the done-pulse cycle (ready=1 timing).
                start     = pokes && (cyc == 60 || cyc == 200 || cyc == 290);
                rst       = (abort_cyc >= 0 && cyc == abort_cyc);
                out_ready = ready_val(ready_mode, cyc);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        fill_model(1'b0);
        init_vecs();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 128'(obs()), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reference pass: model values, ready high, timeline recorded for the vector table.
        run_pass(0, 1'b0, -1, 1'b1);
        foreach (vecs[k]) begin
            check($sformatf("vec_cyc%0d", vecs[k].cyc), 128'(rec[vecs[k].cyc]),
                  128'(vecs[k].exp));
        end

        fill_model(1'b1); run_pass(0, 1'b1, -1, 1'b0);   // start pokes ignored
        fill_model(1'b1); run_pass(1, 1'b0, -1, 1'b0);   // ready 1,0,0,1
        fill_model(1'b1); run_pass(2, 1'b0, 50, 1'b0);   // reset mid-COMPUTE
        fill_model(1'b1); run_pass(2, 1'b0, -1, 1'b0);   // random ready, full pass
        fill_model(1'b1); run_pass(0, 1'b0, 216, 1'b0);  // reset at out_addr=70
        fill_model(1'b0); run_pass(0, 1'b0, -1, 1'b0);   // fresh pass from addr 0

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/s2_window_sequencer.md
Name: s2_window_sequencer

Overview:
- Control and collection end of the stage-2 convolution datapath.
- On start, steps the combinational stage-2 processing block through every 3x3 window position for every filter, one position per clock.
- Captures each post-ReLU result into a 144-entry result buffer.
- Then streams the buffer to the next stage over a valid/ready interface in address order.

Parameters:
- NFILT, 4, number of filters (drives proc_dir).
- OUT_DIM, 6, output feature-map side: 8x8 input, 3x3 kernel, no padding.
- DWIDTH, 35, result width (ReLU output width).
- NOUT, NFILT*OUT_DIM*OUT_DIM = 144, buffer depth; derived, not overridable.

Ports:
- clk  in  1  system clock; only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a full pass; honoured only in IDLE.
- busy  out  1  high in COMPUTE and DRAIN.
- done  out  1  one-cycle pulse after the last output beat is accepted.
- proc_dir  out  2  filter select to the processing block.
- proc_row  out  3  window top-left row, 0..OUT_DIM-1.
- proc_col  out  3  window top-left column, 0..OUT_DIM-1.
- res_in  in  DWIDTH  ReLU result from the processing block for the current proc_dir/row/col; combinational, same cycle.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream ready.
- out_data  out  DWIDTH  buffered result.
- out_addr  out  8  buffer index of out_data, f*36 + r*6 + c.
- out_last  out  1  high with the beat at out_addr = 143.

Behaviour:
- Reset (synchronous, rst sampled high at a clk edge):
  - State goes to IDLE.
  - busy, done, out_valid and out_last go to 0.
  - proc_dir, proc_row, proc_col, out_addr and out_data go to 0.
  - Buffer contents are not cleared.
  - Reset in COMPUTE or DRAIN aborts the pass, emits no done, and the partial stream is discarded.
- IDLE:
  - Outputs hold their reset values.
  - start=1 moves to COMPUTE on the next edge, with proc_dir/row/col = 0/0/0 and busy=1.
- COMPUTE:
  - Every cycle, res_in is written to buf[proc_dir*36 + proc_row*6 + proc_col] at the clock edge.
  - Coordinates then advance in this order: col increments first; col wraps 5->0 and increments row; row wraps 5->0 and increments dir.
  - Exactly 144 cycles, with no stalls.
  - On the cycle that writes (dir=3, row=5, col=5), the next state is DRAIN.
  - Coordinates return to 0 and out_addr is set to 0.
  - start is ignored.
- DRAIN:
  - out_valid=1; out_data = buf[out_addr], registered, so the first valid beat appears 1 cycle after DRAIN entry.
  - out_data, out_addr and out_last hold stable while out_valid=1 and out_ready=0.
  - Each handshake (out_valid and out_ready) advances out_addr by 1 and presents the next entry in the following cycle.
  - Full throughput is 1 beat per cycle with out_ready held high.
  - On the handshake at out_addr=143:
    - out_valid goes to 0 next cycle;
    - done=1 for exactly one cycle;
    - busy goes to 0;
    - state returns to IDLE.
  - start is ignored.
- Simultaneous events:
  - rst has priority over everything.
  - start asserted on the same cycle done pulses is ignored; start must be re-asserted in IDLE.
- Widths and limits:
  - res_in is stored unmodified; no arithmetic in this block.
  - out_addr never exceeds 143.
  - proc_row/proc_col never exceed 5.
- Latency:
  - Pass latency from start to first valid beat is 146 cycles.
  - With out_ready=1 throughout, the last beat is accepted at cycle 289 and done pulses at cycle 290.

Test Plan:
- Reset then start, res_in driven as the model value dir*1000 + row*10 + col, out_ready=1 -> 144 beats in order; out_addr=k carries the model value for the decoded (f,r,c) (e.g. addr 43 -> 1011, addr 143 -> 3055); out_last only at 143; done pulses once.
- Coordinate sweep check -> proc_col cycles 0..5, proc_row steps on each col wrap, proc_dir steps at cycles 36/72/108 of COMPUTE; 144 distinct tuples with no repeats.
- out_ready toggling with pattern 1,0,0,1 -> out_data and out_addr stable on every stall cycle; no beat skipped or duplicated; all 144 beats delivered.
- start pulsed during COMPUTE and during DRAIN -> no restart; coordinate and addr sequences unchanged; a single done.
- rst asserted at COMPUTE cycle 50, then released with a new start -> busy=0 and all outputs 0 the cycle after rst; the new pass begins at 0/0/0 and completes normally.
- rst asserted mid-DRAIN at out_addr=70 with out_ready=1 -> out_valid=0 next cycle; no done; a fresh pass streams from addr 0.
